cmp_share_ctrl: RTL and testbench
=================================

Name: cmp_share_ctrl

Overview:
Controller that shares one less-than comparator between two requesters in the FPU datapath (e.g. exponent-compare and integer-SLT paths). Both requesters use a valid/ready handshake, and the controller arbitrates between them round-robin. It captures the operands, runs the comparator for a fixed number of cycles, and returns the 1-bit result to the granted requester over a valid/ready response channel. Only one comparison is in flight at a time.

Parameters:
WIDTH, 32, operand width in bits.
CMP_LATENCY, 1, cycles spent in CMP state; legal range 1..15.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  controller accepts requester 0 this cycle
req0_a  input  WIDTH  requester 0 left operand
req0_b  input  WIDTH  requester 0 right operand
req0_signed  input  1  1 = two's-complement compare, 0 = unsigned
resp0_valid  output  1  result available for requester 0
resp0_lt  output  1  1 when a < b
resp0_ready  input  1  requester 0 consumes result
req1_valid, req1_ready, req1_a, req1_b, req1_signed  same as requester 0, for requester 1
resp1_valid, resp1_lt, resp1_ready  same as requester 0, for requester 1
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous and active-high; all state is updated only on the rising edge of clk.
- Reset values:
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - req*_ready=0, resp*_valid=0, resp*_lt=0, busy=0.
  - Operand and result registers are cleared to 0; the latency counter is cleared to 0.
- State machine: IDLE -> CMP -> RESP -> IDLE.
- IDLE:
  - The grant goes to the single valid requester, or, if both are valid, to the requester that is not last_grant.
  - req<g>_ready=1 combinationally for the granted requester only; the other requester's ready=0.
  - On valid&ready: capture a, b and signed plus the grant index g, load counter=CMP_LATENCY-1, and move to CMP.
  - With no valid requester: stay in IDLE, all ready outputs 0.
- CMP:
  - Hold the captured operands.
  - If counter!=0, decrement the counter.
  - If counter==0, register lt = signed ? ($signed(a) < $signed(b)) : (a < b) and move to RESP.
  - All req*_ready=0 in this state.
- RESP:
  - resp<g>_valid=1 and resp<g>_lt=the registered result; both are held stable until resp<g>_ready=1.
  - On that handshake: set last_grant=g, deassert valid in the next cycle, return to IDLE.
  - The non-granted requester's resp_valid stays 0 throughout.
- Latency: with CMP_LATENCY=1 and resp_ready held high, a request accepted at edge N gives resp_valid high after edge N+1. The response handshake happens at edge N+2, and the next request can be accepted at edge N+3.
- Arithmetic rules:
  - Equal operands give lt=0.
  - Signed mode: the MSB is the sign bit.
  - Unsigned mode: plain magnitude compare.
  - Operand width is WIDTH; the result is exactly 1 bit.
- Requester obligations: hold valid and operands stable until ready is seen.
- Controller guarantees:
  - The controller never asserts ready to a requester whose valid is low.
  - A pending request is never dropped.
- Fairness: if both requesters stay valid continuously, grants alternate 0,1,0,1…
- Simultaneous events: a valid that rises during CMP or RESP is only considered once the controller returns to IDLE. The RESP-exit edge does not accept a new request.
- Backpressure: resp_ready low holds the controller in RESP indefinitely.
- Reset mid-operation: any in-flight transaction is discarded with no response, and last_grant returns to 1.

Test Plan:
- Single request, unsigned: req0 a=49, b=67, signed=0 -> req0_ready in the first IDLE cycle; resp0_valid=1 and resp0_lt=1 two edges after acceptance; resp1_valid stays 0.
- Signed versus unsigned: a=32'hFFFFFFFF, b=0 -> signed=1 gives lt=1; signed=0 gives lt=0. Equal operands a=b=5 -> lt=0 in both modes.
- Contention: req0 and req1 both valid continuously for 4 transactions -> grant order 0,1,0,1; each response goes only to the granted requester, with the correct lt.
- Backpressure: resp0_ready held low for 5 cycles -> resp0_valid and resp0_lt held stable, busy=1, req1_ready=0; one cycle after resp0_ready=1, the controller returns to IDLE and then serves req1.
- Latency parameter: CMP_LATENCY=4 -> resp_valid is asserted 5 edges after acceptance, with busy=1 throughout.
- Reset mid-operation: assert reset while in CMP -> next cycle all outputs are 0 and state=IDLE; no response is issued; after reset, with both requesters valid, req0 is granted first.

Source files
------------

// File: rtl/cmp_share_ctrl.sv
// Round-robin share of one less-than comparator between two valid/ready requesters.
// One operation in flight: IDLE accepts, CMP runs CMP_LATENCY cycles, RESP holds result until taken.
module cmp_share_ctrl #(
  parameter int WIDTH       = 32,
  parameter int CMP_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_signed,
  output logic             resp0_valid,
  output logic             resp0_lt,
  input  logic             resp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_signed,
  output logic             resp1_valid,
  output logic             resp1_lt,
  input  logic             resp1_ready,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(CMP_LATENCY - 1);

  logic [1:0]       r_state;
  logic             r_last_grant;
  logic             r_grant;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic             r_lt;
  logic [3:0]       r_cnt;

  logic w_grant;
  logic w_accept;
  logic w_resp_hs;
  logic w_lt;

  // Tie goes to whoever was not served last; otherwise the lone valid requester.
  assign w_grant   = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  assign w_accept  = (r_state == S_IDLE) && (req0_valid || req1_valid);
  assign w_resp_hs = (r_state == S_RESP) && (r_grant ? resp1_ready : resp0_ready);
  assign w_lt      = r_signed ? ($signed(r_a) < $signed(r_b)) : (r_a < r_b);

  assign req0_ready  = (r_state == S_IDLE) && req0_valid && !w_grant;
  assign req1_ready  = (r_state == S_IDLE) && req1_valid && w_grant;
  assign resp0_valid = (r_state == S_RESP) && !r_grant;
  assign resp1_valid = (r_state == S_RESP) && r_grant;
  assign resp0_lt    = resp0_valid && r_lt;
  assign resp1_lt    = resp1_valid && r_lt;
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_signed     <= 1'b0;
      r_lt         <= 1'b0;
      r_cnt        <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_grant  <= w_grant;
            r_a      <= w_grant ? req1_a : req0_a;
            r_b      <= w_grant ? req1_b : req0_b;
            r_signed <= w_grant ? req1_signed : req0_signed;
            r_cnt    <= CNT_INIT;
            r_state  <= S_CMP;
          end
        end
        S_CMP: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_lt    <= w_lt;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_resp_hs) begin
            r_last_grant <= r_grant;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_share_ctrl.sv
// Directed bench for cmp_share_ctrl: latency-1 instance plus a CMP_LATENCY=4 instance.
module tb_cmp_share_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r0v = 0, r0s = 0, s0r = 0, r1v = 0, r1s = 0, s1r = 0;
  logic [31:0] r0a = 0, r0b = 0, r1a = 0, r1b = 0;
  logic        req0_ready, req1_ready, resp0_valid, resp0_lt, resp1_valid, resp1_lt, busy;

  logic        b0v = 0, b0s = 0, bs0r = 0;
  logic [31:0] b0a = 0, b0b = 0;
  logic        b_req0_ready, b_req1_ready, b_resp0_valid, b_resp0_lt;
  logic        b_resp1_valid, b_resp1_lt, b_busy;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  cmp_share_ctrl #(.WIDTH(32), .CMP_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(r0v), .req0_ready(req0_ready), .req0_a(r0a), .req0_b(r0b), .req0_signed(r0s),
    .resp0_valid(resp0_valid), .resp0_lt(resp0_lt), .resp0_ready(s0r),
    .req1_valid(r1v), .req1_ready(req1_ready), .req1_a(r1a), .req1_b(r1b), .req1_signed(r1s),
    .resp1_valid(resp1_valid), .resp1_lt(resp1_lt), .resp1_ready(s1r),
    .busy(busy)
  );

  cmp_share_ctrl #(.WIDTH(32), .CMP_LATENCY(4)) dut_lat4 (
    .clk(clk), .reset(reset),
    .req0_valid(b0v), .req0_ready(b_req0_ready), .req0_a(b0a), .req0_b(b0b), .req0_signed(b0s),
    .resp0_valid(b_resp0_valid), .resp0_lt(b_resp0_lt), .resp0_ready(bs0r),
    .req1_valid(1'b0), .req1_ready(b_req1_ready), .req1_a(32'd0), .req1_b(32'd0), .req1_signed(1'b0),
    .resp1_valid(b_resp1_valid), .resp1_lt(b_resp1_lt), .resp1_ready(1'b1),
    .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one bounded transaction on a single requester; reports whether a response came back and its lt.
  task automatic xact(input int idx, input logic [31:0] a, input logic [31:0] b, input logic s,
                      output logic ok, output logic lt);
    int n;
    ok = 1'b0;
    lt = 1'b0;
    if (idx == 0) begin r0v = 1; r0a = a; r0b = b; r0s = s; s0r = 1; end
    else          begin r1v = 1; r1a = a; r1b = b; r1s = s; s1r = 1; end
    #1;
    n = 0;
    while (!(idx == 0 ? req0_ready : req1_ready) && n < 20) begin tick(); n++; end
    if (n < 20) begin
      tick();
      r0v = 0; r1v = 0;
      #1;
      n = 0;
      while (!(idx == 0 ? resp0_valid : resp1_valid) && n < 20) begin tick(); n++; end
      if (n < 20) begin
        ok = 1'b1;
        lt = (idx == 0) ? resp0_lt : resp1_lt;
        tick();
      end
    end
    r0v = 0; r1v = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) tick();
    reset = 0;
    #1;
    vecs++;
    if ({req0_ready, req1_ready, resp0_valid, resp0_lt, resp1_valid, resp1_lt, busy} !== 7'b0) begin
      errs++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {req0_ready, req1_ready, resp0_valid, resp0_lt, resp1_valid, resp1_lt, busy});
    end
    vecs++;
    if ({b_req0_ready, b_resp0_valid, b_busy} !== 3'b0) begin
      errs++;
      $display("FAIL reset_outputs_lat4: got %b want 000", {b_req0_ready, b_resp0_valid, b_busy});
    end
  endtask

  task automatic test_single_unsigned();
    r0v = 1; r0a = 49; r0b = 67; r0s = 0; s0r = 1;
    #1;
    vecs++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errs++; $display("FAIL single_ready: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
    tick();
    r0v = 0;
    #1;
    vecs++;
    if (busy !== 1'b1 || resp0_valid !== 1'b0) begin
      errs++; $display("FAIL single_cmp: got busy=%b v=%b want 1 0", busy, resp0_valid);
    end
    tick();
    vecs++;
    if (resp0_valid !== 1'b1 || resp0_lt !== 1'b1 || resp1_valid !== 1'b0) begin
      errs++; $display("FAIL single_resp: got v0=%b lt=%b v1=%b want 1 1 0", resp0_valid, resp0_lt, resp1_valid);
    end
    tick();
    vecs++;
    if (resp0_valid !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL single_done: got v0=%b busy=%b want 0 0", resp0_valid, busy);
    end
  endtask

  task automatic test_signed_unsigned();
    logic [31:0] ta [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5, 32'hFFFFFFFE};
    logic [31:0] tb [5] = '{32'd0,        32'd0,        32'd5, 32'd5, 32'hFFFFFFFF};
    logic        ts [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        te [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic ok, lt;
    for (int i = 0; i < 5; i++) begin
      xact(i % 2, ta[i], tb[i], ts[i], ok, lt);
      vecs++;
      if (ok !== 1'b1 || lt !== te[i]) begin
        errs++; $display("FAIL signed_case%0d: got ok=%b lt=%b want ok=1 lt=%b", i, ok, lt, te[i]);
      end
    end
  endtask

  task automatic test_contention();
    logic exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic exp_lt;
    reset = 1; tick(); reset = 0;
    r0v = 1; r0a = 1; r0b = 2; r0s = 0; s0r = 1;
    r1v = 1; r1a = 9; r1b = 3; r1s = 0; s1r = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_lt = (exp_g[k] == 1'b0);
      vecs++;
      if (req0_ready !== ~exp_g[k] || req1_ready !== exp_g[k]) begin
        errs++; $display("FAIL contention_grant%0d: got r0=%b r1=%b want grant %0d", k, req0_ready, req1_ready, exp_g[k]);
      end
      tick();
      vecs++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errs++; $display("FAIL contention_cmp_ready%0d: got r0=%b r1=%b want 0 0", k, req0_ready, req1_ready);
      end
      tick();
      vecs++;
      if (resp0_valid !== ~exp_g[k] || resp1_valid !== exp_g[k] ||
          (exp_g[k] ? resp1_lt : resp0_lt) !== exp_lt) begin
        errs++; $display("FAIL contention_resp%0d: got v0=%b v1=%b lt0=%b lt1=%b want grant %0d lt=%b",
                         k, resp0_valid, resp1_valid, resp0_lt, resp1_lt, exp_g[k], exp_lt);
      end
      tick();
    end
    r0v = 0; r1v = 0;
    #1;
  endtask

  task automatic test_backpressure();
    r0v = 1; r0a = 3; r0b = 7; r0s = 0; s0r = 0;
    #1;
    vecs++;
    if (req0_ready !== 1'b1) begin
      errs++; $display("FAIL bp_accept: got r0_ready=%b want 1", req0_ready);
    end
    tick();
    r0v = 0;
    r1v = 1; r1a = 7; r1b = 3; r1s = 0; s1r = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      vecs++;
      if (resp0_valid !== 1'b1 || resp0_lt !== 1'b1 || busy !== 1'b1 || req1_ready !== 1'b0 || resp1_valid !== 1'b0) begin
        errs++; $display("FAIL bp_hold%0d: got v0=%b lt=%b busy=%b r1rdy=%b v1=%b want 1 1 1 0 0",
                         k, resp0_valid, resp0_lt, busy, req1_ready, resp1_valid);
      end
      tick();
    end
    s0r = 1;
    #1;
    tick();
    vecs++;
    if (resp0_valid !== 1'b0 || busy !== 1'b0 || req1_ready !== 1'b1) begin
      errs++; $display("FAIL bp_release: got v0=%b busy=%b r1rdy=%b want 0 0 1", resp0_valid, busy, req1_ready);
    end
    tick();
    r1v = 0;
    tick();
    vecs++;
    if (resp1_valid !== 1'b1 || resp1_lt !== 1'b0 || resp0_valid !== 1'b0) begin
      errs++; $display("FAIL bp_serve_req1: got v1=%b lt1=%b v0=%b want 1 0 0", resp1_valid, resp1_lt, resp0_valid);
    end
    tick();
  endtask

  task automatic test_latency4();
    b0v = 1; b0a = 10; b0b = 20; b0s = 0; bs0r = 1;
    #1;
    vecs++;
    if (b_req0_ready !== 1'b1) begin
      errs++; $display("FAIL lat4_accept: got ready=%b want 1", b_req0_ready);
    end
    tick();
    b0v = 0;
    for (int k = 0; k < 4; k++) begin
      vecs++;
      if (b_resp0_valid !== 1'b0 || b_busy !== 1'b1) begin
        errs++; $display("FAIL lat4_wait%0d: got v=%b busy=%b want 0 1", k, b_resp0_valid, b_busy);
      end
      tick();
    end
    vecs++;
    if (b_resp0_valid !== 1'b1 || b_resp0_lt !== 1'b1 || b_busy !== 1'b1) begin
      errs++; $display("FAIL lat4_resp: got v=%b lt=%b busy=%b want 1 1 1", b_resp0_valid, b_resp0_lt, b_busy);
    end
    tick();
    vecs++;
    if (b_busy !== 1'b0 || b_resp0_valid !== 1'b0) begin
      errs++; $display("FAIL lat4_done: got busy=%b v=%b want 0 0", b_busy, b_resp0_valid);
    end
  endtask

  task automatic test_reset_midop();
    logic ok, lt;
    xact(0, 32'd1, 32'd1, 1'b0, ok, lt);
    r0v = 1; r0a = 2; r0b = 8; r0s = 0; s0r = 1;
    tick();
    r0v = 0;
    #1;
    vecs++;
    if (busy !== 1'b1) begin
      errs++; $display("FAIL midop_in_cmp: got busy=%b want 1", busy);
    end
    reset = 1;
    tick();
    reset = 0;
    #1;
    vecs++;
    if ({req0_ready, req1_ready, resp0_valid, resp0_lt, resp1_valid, resp1_lt, busy} !== 7'b0) begin
      errs++; $display("FAIL midop_reset_outputs: got %b want 0000000",
                       {req0_ready, req1_ready, resp0_valid, resp0_lt, resp1_valid, resp1_lt, busy});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vecs++;
      if (resp0_valid !== 1'b0 || busy !== 1'b0) begin
        errs++; $display("FAIL midop_no_resp%0d: got v0=%b busy=%b want 0 0", k, resp0_valid, busy);
      end
    end
    r0v = 1; r0a = 4; r0b = 4; r1v = 1; r1a = 4; r1b = 4;
    #1;
    vecs++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errs++; $display("FAIL midop_first_grant: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
    tick();
    r0v = 0; r1v = 0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single_unsigned();
    test_signed_unsigned();
    test_contention();
    test_backpressure();
    test_latency4();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
